// File: rtl/sequence_controller.sv
// Character sequencer: buffers scan codes and steps the glyph datapath
// through clear/load/draw for each character, with a VGA plot strobe.
module sequence_controller #(
  parameter int DEPTH         = 16,
  parameter int CHARS_PER_ROW = 8,
  parameter int X_ORIGIN      = 8,
  parameter int Y_ORIGIN      = 8,
  parameter int PITCH         = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clear_buf,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] address,
  output logic [8:0] x_input,
  output logic [8:0] y_input,
  output logic       ld_value,
  output logic       ld_colour,
  output logic       reset_counter,
  output logic       enable_counter,
  output logic       next_colour,
  output logic       plot
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, CLEAR, LOAD, DRAW, TAIL, NEXT, DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_nxt;
  logic [7:0]    col;
  logic [4:0]    cnt;
  logic          wr_ok;

  assign idx_nxt = idx + LW'(1);
  assign wr_ok   = (state == IDLE) && wr_en && !clear_buf &&
                   !start && (len != LW'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[len[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      len            <= '0;
      idx            <= '0;
      col            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      address        <= '0;
      x_input        <= '0;
      y_input        <= '0;
      ld_value       <= 1'b0;
      ld_colour      <= 1'b0;
      reset_counter  <= 1'b0;
      enable_counter <= 1'b0;
      next_colour    <= 1'b0;
      plot           <= 1'b0;
    end else begin
      plot           <= enable_counter;
      done           <= 1'b0;
      ld_value       <= 1'b0;
      ld_colour      <= 1'b0;
      reset_counter  <= 1'b0;
      enable_counter <= 1'b0;
      next_colour    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            col     <= '0;
            x_input <= 9'(X_ORIGIN);
            y_input <= 9'(Y_ORIGIN);
            busy    <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              address <= mem[0];
            end
          end else if (clear_buf) begin
            len <= '0;
          end else if (wr_ok) begin
            len <= len + LW'(1);
          end
        end
        FETCH: begin
          if (address == 8'h29) begin
            state <= NEXT;
          end else begin
            state         <= CLEAR;
            reset_counter <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= LOAD;
          ld_value  <= 1'b1;
          ld_colour <= 1'b1;
        end
        LOAD: begin
          state          <= DRAW;
          cnt            <= '0;
          enable_counter <= 1'b1;
          next_colour    <= 1'b1;
        end
        DRAW: begin
          if (cnt == 5'd24) begin
            state <= TAIL;
          end else begin
            cnt            <= cnt + 5'd1;
            enable_counter <= 1'b1;
            next_colour    <= 1'b1;
          end
        end
        TAIL: state <= NEXT;
        NEXT: begin
          idx <= idx_nxt;
          // Cursor advances incrementally; wraps to the next text row
          if (col == 8'(CHARS_PER_ROW - 1)) begin
            col     <= '0;
            x_input <= 9'(X_ORIGIN);
            y_input <= y_input + 9'(PITCH);
          end else begin
            col     <= col + 8'd1;
            x_input <= x_input + 9'(PITCH);
          end
          if (idx_nxt == len) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= FETCH;
            address <= mem[idx_nxt[AW-1:0]];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_controller.sv
// Scoreboard bench for sequence_controller: directed strings,
// expected loads and done timing queued, monitor compares.
module tb_sequence_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clear_buf = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [7:0] address;
  logic [8:0] x_input, y_input;
  logic       ld_value, ld_colour, reset_counter;
  logic       enable_counter, next_colour, plot;

  sequence_controller dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .clear_buf(clear_buf), .start(start), .busy(busy), .done(done),
    .address(address), .x_input(x_input), .y_input(y_input),
    .ld_value(ld_value), .ld_colour(ld_colour),
    .reset_counter(reset_counter), .enable_counter(enable_counter),
    .next_colour(next_colour), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [8:0] x;
    logic [8:0] y;
  } chr_t;

  typedef struct {
    int cyc;
    int plots;
  } done_t;

  chr_t  exp_chr[$];
  done_t exp_done[$];

  int cyc = 0;
  int start_cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  logic       prev_en = 0, prev_rc = 0, prev_plot = 0, busy_next = 0;
  int         run = 0, plots = 0;
  logic [7:0] addr_ld = 0;
  chr_t       mc;
  done_t      md;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 0; prev_rc = 0; prev_plot = 0;
      run = 0; plots = 0; busy_next = 0;
    end else begin
      chk("plot_lag", 32'(plot), 32'(prev_en));
      chk("strobe_excl",
          {27'd0, reset_counter & ld_value, reset_counter & enable_counter,
           ld_value & enable_counter, ld_colour ^ ld_value,
           next_colour ^ enable_counter}, 0);
      if (ld_value) begin
        checks++;
        if (exp_chr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: got address %0h expected none",
                   address);
        end else begin
          mc = exp_chr.pop_front();
          chk("address", 32'(address), 32'(mc.a));
          chk("x_input", 32'(x_input), 32'(mc.x));
          chk("y_input", 32'(y_input), 32'(mc.y));
        end
        chk("clear_before_load", 32'(prev_rc), 1);
        addr_ld = address;
      end
      if (enable_counter) run++;
      else if (prev_en) begin
        chk("enable_run", run, 25);
        run = 0;
      end
      if (plot) plots++;
      if (prev_plot && !plot) chk("address_stable", 32'(address), 32'(addr_ld));
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none",
                   cyc - start_cyc);
        end else begin
          md = exp_done.pop_front();
          chk("done_cycle", cyc - start_cyc, md.cyc);
          chk("plot_count", plots, md.plots);
        end
        chk("busy_at_done", 32'(busy), 1);
        plots = 0;
        busy_next = 1;
      end else if (busy_next) begin
        chk("busy_after_done", 32'(busy), 0);
        busy_next = 0;
      end
      prev_en = enable_counter;
      prev_rc = reset_counter;
      prev_plot = plot;
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic clr();
    @(negedge clk);
    clear_buf = 1;
    @(negedge clk);
    clear_buf = 0;
  endtask

  task automatic push_chr(input logic [7:0] a, input int x, input int y);
    exp_chr.push_back('{a, 9'(x), 9'(y)});
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", exp_done.size(), 0);
    exp_done.delete();
    chk("chars_left", exp_chr.size(), 0);
    exp_chr.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic go(input int dc, input int pl, input logic w,
                    input logic [7:0] d);
    exp_done.push_back('{dc, pl});
    @(negedge clk);
    start = 1; wr_en = w; wr_data = d;
    start_cyc = cyc;
    @(negedge clk);
    start = 0; wr_en = 0;
    wait_done();
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!enable_counter && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("enable_seen", 32'(enable_counter), 1);
  endtask

  logic [7:0] nine [9] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25,
                           8'h2E, 8'h36, 8'h3D, 8'h3E};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(address), 0);
    chk("rst_xy", {14'd0, x_input, y_input}, 0);
    chk("rst_strobes", {24'd0, busy, done, ld_value, ld_colour,
        reset_counter, enable_counter, next_colour, plot}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_strobes", {24'd0, busy, done, ld_value, ld_colour,
        reset_counter, enable_counter, next_colour, plot}, 0);

    // Two characters on one row
    wr(8'h33); wr(8'h43);
    push_chr(8'h33, 8, 8);
    push_chr(8'h43, 32, 8);
    go(61, 50, 0, 0);

    // Nine characters: row wrap after the eighth
    clr();
    foreach (nine[i]) wr(nine[i]);
    push_chr(8'h15, 8, 8);   push_chr(8'h16, 32, 8);
    push_chr(8'h1E, 56, 8);  push_chr(8'h26, 80, 8);
    push_chr(8'h25, 104, 8); push_chr(8'h2E, 128, 8);
    push_chr(8'h36, 152, 8); push_chr(8'h3D, 176, 8);
    push_chr(8'h3E, 8, 32);
    go(271, 225, 0, 0);

    // Space in the middle
    clr();
    wr(8'h16); wr(8'h29); wr(8'h1E);
    push_chr(8'h16, 8, 8);
    push_chr(8'h1E, 56, 8);
    go(63, 50, 0, 0);

    // clear_buf beats wr_en: empty string
    @(negedge clk);
    clear_buf = 1; wr_en = 1; wr_data = 8'h33;
    @(negedge clk);
    clear_buf = 0; wr_en = 0;
    go(1, 0, 0, 0);

    // start beats wr_en; contents persist for a redraw
    wr(8'h33);
    push_chr(8'h33, 8, 8);
    go(31, 25, 1, 8'h43);
    push_chr(8'h33, 8, 8);
    go(31, 25, 0, 0);

    // Full buffer: 16 spaces, 17th write dropped
    clr();
    for (int i = 0; i < 16; i++) wr(8'h29);
    wr(8'h33);
    go(33, 0, 0, 0);

    // start/wr_en pulses during DRAW are ignored
    clr();
    wr(8'h33); wr(8'h43);
    push_chr(8'h33, 8, 8);
    push_chr(8'h43, 32, 8);
    exp_done.push_back('{61, 50});
    @(negedge clk);
    start = 1;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    wait_enable();
    repeat (3) @(negedge clk);
    start = 1; wr_en = 1; wr_data = 8'h1E;
    @(negedge clk);
    start = 0; wr_en = 0;
    wait_done();
    push_chr(8'h33, 8, 8);
    push_chr(8'h43, 32, 8);
    go(61, 50, 0, 0);

    // Asynchronous reset mid-DRAW
    push_chr(8'h33, 8, 8);
    @(negedge clk);
    start = 1;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    wait_enable();
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_addr", 32'(address), 0);
    chk("async_xy", {14'd0, x_input, y_input}, 0);
    chk("async_strobes", {24'd0, busy, done, ld_value, ld_colour,
        reset_counter, enable_counter, next_colour, plot}, 0);
    exp_chr.delete();
    exp_done.delete();
    @(negedge clk);
    #2 rst_n = 1;
    go(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
